// File: rtl/sobel_pkg.sv
// Shared pixel/window types and defaults for the Sobel front end.
// Window element (r,c) sits at bit offset DATA_WIDTH*win_elem(r,c), r=0 top, c=0 left.
package sobel_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_IMG_WIDTH  = 100;
  localparam int DEF_IMG_HEIGHT = 100;

  typedef logic [DEF_DATA_WIDTH-1:0]   pixel_t;
  typedef logic [9*DEF_DATA_WIDTH-1:0] window_t;

  function automatic int unsigned win_elem(input int unsigned r, input int unsigned c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: data_out is the pixel written DEPTH shifts ago.
// Latency DEPTH accepted pixels; advances only on shift_en, no reset (contents masked upstream).
module line_buffer #(
  parameter int DEPTH      = 100,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign data_out = mem[DEPTH-1];

endmodule

// File: rtl/sobel_window_reader.sv
// Builds 3x3 windows from the raster stream plus two line-buffer taps; win one cycle after accept.
// Single output register: in_ready drops while a window is held unaccepted, freezing everything.
module sobel_window_reader
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  input  logic [DATA_WIDTH-1:0]   lb0_out,
  input  logic [DATA_WIDTH-1:0]   lb1_out,
  output logic                    lb_shift_en,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [9*DATA_WIDTH-1:0] win,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [9*DATA_WIDTH-1:0] win_q;
  logic                    accept;
  logic                    col_last;
  logic                    row_last;
  logic                    win_ok;

  assign in_ready    = !win_valid || win_ready;
  assign accept      = in_valid && in_ready;
  assign lb_shift_en = accept;

  assign col_last = (col == CW'(IMG_WIDTH - 1));
  assign row_last = (row == RW'(IMG_HEIGHT - 1));
  // The first two columns/rows of a frame would pull in the previous row/frame.
  assign win_ok   = (col >= CW'(2)) && (row >= RW'(2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_q      <= '0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) begin
          row <= row_last ? '0 : row + 1'b1;
        end
        win_valid <= win_ok;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 2; c++) begin
            win_q[DATA_WIDTH*win_elem(r, c) +: DATA_WIDTH] <=
              win_q[DATA_WIDTH*win_elem(r, c+1) +: DATA_WIDTH];
          end
        end
        win_q[DATA_WIDTH*win_elem(0, 2) +: DATA_WIDTH] <= lb1_out;
        win_q[DATA_WIDTH*win_elem(1, 2) +: DATA_WIDTH] <= lb0_out;
        win_q[DATA_WIDTH*win_elem(2, 2) +: DATA_WIDTH] <= in_pixel;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  assign win = win_q;

endmodule
